data_sram_slave: RTL and testbench
==================================

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning log2 of memory depth in 32-bit words (16 KB at the default).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 1..15, meaning stall cycles per access; used only under DATA_SRAM_WAIT_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_sram_en, input, 1 bit: access request.
REQ-006 SHALL have port data_sram_wen, input, 4 bits: byte write enables; wen[i] writes wdata[8i+7:8i]; 4'b0000 with en means read.
REQ-007 SHALL have port data_sram_addr, input, 32 bits: byte address.
REQ-008 SHALL have port data_sram_wdata, input, 32 bits: store data, already lane-aligned by the requester.
REQ-009 SHALL have port data_sram_rdata, output, 32 bits: full word read data; the requester does lane select and extension.
REQ-010 SHALL have port data_sram_stall, output, 1 bit: high while an access is outstanding; the requester holds en/wen/addr/wdata stable while high.

Function
REQ-011 SHALL hold 2^ADDR_W 32-bit words, indexed by addr[ADDR_W+1:2]; addr[1:0] and addr[31:ADDR_W+2] ignored (aliasing wrap-around, no alignment fault).
REQ-012 SHALL, base mode, accept any en cycle, taking 1 cycle to complete.
REQ-013 SHALL register the read word into rdata at the completing edge, valid from the next cycle (1-cycle read latency).
REQ-014 SHALL write only the enabled byte lanes at the completing edge; disabled lanes keep their old contents.
REQ-015 SHALL keep rdata unchanged on write, idle (en=0) and stall cycles; rdata holds the last completed read.
REQ-016 SHALL return the just-written data for a read issued the cycle after a write to the same word (no stale data).
REQ-017 SHALL treat en=0 as no operation regardless of wen/addr/wdata.
REQ-018 SHALL in wait mode run FSM IDLE -> WAIT -> DONE -> IDLE:
- IDLE: en=1 loads counter with WAIT_CYCLES-1, enters WAIT, stall=1;
- WAIT: counter decrements each cycle, stall=1; at counter 0 enters DONE;
- DONE: stall=0, commits write or registers rdata at this edge, returns to IDLE.
REQ-019 SHALL drive stall combinationally: high in IDLE when en=1, and high throughout WAIT.
REQ-020 SHALL, when en is high again in DONE's completing cycle, treat it as a new access (back-to-back: next access starts in IDLE the following cycle).
REQ-021 SHALL ignore changes to request inputs in WAIT (protocol violation); the values sampled at the completing edge are used.

Reset
REQ-022 SHALL, with resetn low, force rdata=32'h0, stall=0, FSM=IDLE, counter=0 immediately, independent of clk.
REQ-023 SHALL not initialise memory contents on reset.
REQ-024 SHALL abandon an access in WAIT when reset asserts mid-operation; its write is not committed.
REQ-025 SHALL accept a new access on the first rising edge after resetn deasserts.

Configuration
REQ-026 SHALL compile the FSM, counter and stall logic only when macro DATA_SRAM_WAIT_EN is defined; each access then takes WAIT_CYCLES+1 cycles.
REQ-027 SHALL, without DATA_SRAM_WAIT_EN, tie data_sram_stall to 0 and complete every access in one cycle per REQ-012..REQ-017.

Verification
REQ-028 SHALL cover: write addr 0x10 wdata 0xAABBCCDD wen 1111, then read 0x10 -> rdata 0xAABBCCDD one cycle after the read.
REQ-029 SHALL cover: word 0x20 = 0x11223344, write wen 0100 wdata 0x00EE0000, read -> 0x11EE3344.
REQ-030 SHALL cover: ADDR_W=12, write 0x4000 then read 0x0000 and 0x0003 -> same word both times (wrap, low bits ignored).
REQ-031 SHALL cover: read, then idle 3 cycles, then write -> rdata stays at the read value through idle and write.
REQ-032 SHALL cover: wait mode with WAIT_CYCLES=2, read -> stall high 2 cycles, rdata valid the cycle after stall falls; back-to-back reads -> 3-cycle spacing.
REQ-033 SHALL cover: wait mode, resetn pulsed low during WAIT of a write to 0x30 -> stall=0 and rdata=0 at once; later read of 0x30 -> old contents.

Source files
------------

// File: rtl/data_sram_slave.sv
// Word-addressed data SRAM slave with byte-lane writes and registered read data.
// Defining DATA_SRAM_WAIT_EN adds a wait-state FSM: each access takes WAIT_CYCLES+1 cycles.
module data_sram_slave #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_stall
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              commit;
    logic [31:0]       rdata_d;
    logic [31:0]       rdata_q;
    logic              unused_addr;

    // Upper and byte-offset address bits are ignored: the array aliases.
    assign idx         = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DATA_SRAM_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e     state_q;
    logic [3:0] cnt_q;

    // IDLE already counts as the first stall cycle, so WAIT lasts WAIT_CYCLES-1
    // cycles and is skipped entirely when WAIT_CYCLES is 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_sram_en) begin
                        cnt_q   <= 4'(WAIT_CYCLES - 1);
                        state_q <= (WAIT_CYCLES > 1) ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign commit          = resetn && data_sram_en && (state_q == ST_DONE);
    assign data_sram_stall = resetn &&
                             (((state_q == ST_IDLE) && data_sram_en) || (state_q == ST_WAIT));
`else
    logic unused_cfg;

    assign unused_cfg      = (WAIT_CYCLES == 0);
    assign commit          = resetn && data_sram_en;
    assign data_sram_stall = 1'b0;
`endif

    // Storage is never reset; only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit && (data_sram_wen == 4'b0000)) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed self-checking bench for data_sram_slave; wait-mode checks follow DATA_SRAM_WAIT_EN.
module tb_data_sram_slave;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;

    int n_vec;
    int n_err;
    int cyc;

`ifdef DATA_SRAM_WAIT_EN
    localparam int ACC_CYC = 3;
`else
    localparam int ACC_CYC = 1;
`endif

    data_sram_slave #(
        .ADDR_W      (12),
        .WAIT_CYCLES (2)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .data_sram_stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drives one access and waits for it to complete; returns cycles taken.
    task automatic sram_acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                            input bit keep_en, output int c);
        en    = 1'b1;
        wen   = w;
        addr  = a;
        wdata = d;
        c     = 1;
        #1;
        while (stall && c <= 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        @(posedge clk);
        #1;
        if (!keep_en) begin
            en  = 1'b0;
            wen = 4'b0000;
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w);
        int c;
        sram_acc(w, a, d, 1'b0, c);
        check32({tag, "_cyc"}, 32'(c), 32'(ACC_CYC));
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input bit keep_en);
        int c;
        sram_acc(4'b0000, a, 32'h0, keep_en, c);
        check32({tag, "_cyc"}, 32'(c), 32'(ACC_CYC));
        check32(tag, rdata, exp);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        en     = 1'b0;
        wen    = 4'b0000;
        addr   = '0;
        wdata  = '0;
        #3;
        check32("rst_rdata", rdata, 32'h0);
        check32("rst_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        wr("w10", 32'h10, 32'hAABBCCDD, 4'b1111);
        rd("r10", 32'h10, 32'hAABBCCDD, 1'b0);

        wr("w20", 32'h20, 32'h11223344, 4'b1111);
        wr("w20_b2", 32'h20, 32'h00EE0000, 4'b0100);
        rd("r20_b2", 32'h20, 32'h11EE3344, 1'b0);
        wr("w20_b03", 32'h20, 32'h55AAAA66, 4'b1001);
        rd("r20_b03", 32'h20, 32'h55EE3366, 1'b0);

        en    = 1'b0;
        wen   = 4'b1111;
        addr  = 32'h20;
        wdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        wen = 4'b0000;
        check32("noop_rdata", rdata, 32'h55EE3366);
        rd("noop_mem", 32'h20, 32'h55EE3366, 1'b0);

        wr("w4000", 32'h4000, 32'hCAFEF00D, 4'b1111);
        rd("wrap_0", 32'h0, 32'hCAFEF00D, 1'b0);
        rd("wrap_3", 32'h3, 32'hCAFEF00D, 1'b0);

        rd("hold_rd", 32'h10, 32'hAABBCCDD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check32("hold_idle", rdata, 32'hAABBCCDD);
        end
        wr("hold_w", 32'h10, 32'h01020304, 4'b1111);
        check32("hold_wr", rdata, 32'hAABBCCDD);
        rd("hold_new", 32'h10, 32'h01020304, 1'b0);

        wr("w40", 32'h40, 32'h0BADCAFE, 4'b1111);
        rd("b2b_1", 32'h10, 32'h01020304, 1'b1);
        rd("b2b_2", 32'h40, 32'h0BADCAFE, 1'b0);

        wr("w30", 32'h30, 32'h12345678, 4'b1111);
        rd("r30", 32'h30, 32'h12345678, 1'b0);
`ifdef DATA_SRAM_WAIT_EN
        en    = 1'b1;
        wen   = 4'b1111;
        addr  = 32'h30;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        check32("mid_stall", {31'h0, stall}, 32'h1);
`endif
        resetn = 1'b0;
        #1;
        check32("arst_rdata", rdata, 32'h0);
        check32("arst_stall", {31'h0, stall}, 32'h0);
        en  = 1'b0;
        wen = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        rd("r30_after", 32'h30, 32'h12345678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
